la_cdc_tx: RTL and testbench
============================

# la_cdc_tx

Source-side half of a req/ack clock-domain-crossing handshake. It accepts a data word on a valid/ready interface in its local clock domain, then holds that word stable on `out_data` and raises `out_req`. It waits for the remote receiver's acknowledge, which arrives asynchronously and is synchronized internally through `la_dsync`. It pairs with the receive-side block that samples `out_req` through its own synchronizer in the destination domain.

## Interface
- `DW`, default 32: data width.
- `STAGES`, default 2: synchronizer depth for `in_ack`; passed to `la_dsync`.
- `PROP`, default "DEFAULT": implementation property; passed to `la_dsync`.
- `clk` input, 1 bit: local clock. This is the only clock.
- `nreset` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: local word valid.
- `in_data` input, DW bits: local word.
- `in_ready` output, 1 bit: block can accept a word this cycle.
- `in_ack` input, 1 bit: acknowledge from the remote domain; asynchronous to `clk`.
- `out_req` output, 1 bit: request to the remote domain; registered, glitch-free.
- `out_data` output, DW bits: word to the remote domain; registered, stable whenever `out_req` differs from its idle value.
- `busy` output, 1 bit: a transfer is in flight (state is not IDLE).

## Operation
- `ack_s` is `in_ack` passed through `la_dsync` (STAGES flops). The FSM only ever uses `ack_s`.
- Four-phase FSM (default) has three states: IDLE, REQ, RELEASE.
  - IDLE: `in_ready = (ack_s == 0)`. When `in_valid && in_ready`, register `out_data <= in_data` and `out_req <= 1`, then go to REQ.
  - REQ: hold `out_req` and `out_data`. When `ack_s == 1`, set `out_req <= 0` and go to RELEASE.
  - RELEASE: when `ack_s == 0`, go to IDLE. `out_data` keeps its last value and is not cleared.
- `in_ready` is 0 in REQ and RELEASE. `busy = (state != IDLE)`.
- `in_valid` while not ready: the word is ignored and no state changes. The upstream source holds it per valid/ready rules.
- `in_data` is sampled only on the accepting edge. Changes after that edge have no effect.
- Remote ack still high after local reset (remote domain not reset): the FSM stays in IDLE with `in_ready = 0` until `ack_s` falls. No spurious transfer occurs.
- Ack glitch or early ack in IDLE is ignored. Any ack edge other than the expected one in REQ or RELEASE is ignored.

## Timing
- Reset values: `out_req = 0`, `out_data = 0`, `busy = 0`, state IDLE. `in_ready = 1` once `ack_s == 0`, which holds at reset because the synchronizer flops clear.
- Accept latency: `out_req` and `out_data` update on the accepting edge. Both are registered on the same edge, so data is never later than req.
- Ack latency: `out_req` falls STAGES+1 edges after `in_ack` rises, plus up to 1 cycle of metastability uncertainty.
- Minimum period per word (four-phase) is about 2×(STAGES+1) local cycles plus remote-domain latency.
- Reset mid-transfer: `out_req` and `out_data` clear asynchronously. The remote side must tolerate an aborted request.

## Configuration
- `LA_CDC_TX_TWOPHASE_EN` defined: two-phase (toggle) protocol.
  - States are only IDLE and REQ.
  - Accepting a word toggles `out_req` (`out_req <= ~out_req`) and goes to REQ.
  - REQ returns to IDLE when `ack_s == out_req`.
  - In IDLE, `in_ready = (ack_s == out_req)`.
  - Reset values are unchanged.
- Not defined: the four-phase behaviour described above.

## Structure
- Shared package `la_cdc_pkg`: state enum (IDLE, REQ, RELEASE) and the `STAGES` default constant, shared with the receive-side block.
- One sub-module, `la_dsync`, instantiated once for `in_ack`. The FSM and registers live in `la_cdc_tx`.

## Test plan
- Reset check: hold `nreset = 0`, then release -> `out_req = 0`, `out_data = 0`, `busy = 0`, and `in_ready = 1` on the first cycle.
- Single transfer, STAGES=2: `in_data = 0xA5A5_0001` with `in_valid` for 1 cycle.
  - `out_req` rises on the accepting edge and `out_data = 0xA5A5_0001`.
  - The bench acks 5 cycles later; `out_req` falls 3 edges after the ack.
  - The bench drops ack; `in_ready` returns 3 edges after ack low.
- Back-to-back: 4 words 0x1..0x4 presented continuously with the remote modelled as an echo of req -> 4 transfers in order, and `out_data` never changes while `out_req = 1`.
- Stuck ack: `in_ack = 1` through reset release -> `in_ready = 0` and `out_req` stays 0 until ack drops. Then the transfer of 0xDEAD proceeds normally.
- Reset mid-transfer: assert `nreset` while in REQ -> `out_req` and `out_data` clear immediately. After release, a new word 0x55 completes correctly.
- With `LA_CDC_TX_TWOPHASE_EN` defined: 3 words -> `out_req` toggles 0→1→0→1, with each completion occurring when `ack_s` matches `out_req`.

Source files
------------

// File: rtl/la_cdc_pkg.sv
// Shared definitions for the la_cdc transmit and receive halves.
package la_cdc_pkg;

  // Default synchronizer depth used by both sides of the crossing
  localparam int unsigned StagesDefault = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StRelease = 2'd2
  } cdc_state_e;

endpackage

// File: rtl/la_dsync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// PROP selects the implementation; only the generic flop chain exists today.
module la_dsync
  import la_cdc_pkg::*;
#(
  parameter int unsigned STAGES = StagesDefault,
  parameter string       PROP   = "DEFAULT"
) (
  input  logic clk,
  input  logic nreset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the async input down the chain one stage per clock
  always_comb begin
    sync_d[0] = d_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  if (PROP == "DEFAULT") begin : g_generic
    // Plain flop chain, cleared by reset so a fresh domain sees no ack
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) sync_q <= '0;
      else         sync_q <= sync_d;
    end
  end else begin : g_mapped
    // Hook for a library synchronizer cell; behaves as the generic chain
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) sync_q <= '0;
      else         sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/la_cdc_tx.sv
// Source side of a req/ack clock-domain-crossing handshake.
// Accepts a word on valid/ready, holds it on out_data and signals out_req until
// the synchronized remote ack completes the handshake.
// Define LA_CDC_TX_TWOPHASE_EN for the two-phase (toggle) protocol; the default
// build is the four-phase protocol.
module la_cdc_tx
  import la_cdc_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned STAGES = StagesDefault,
  parameter string       PROP   = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          in_ack,
  output logic          out_req,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  logic          ack_s;
  logic          accept;
  cdc_state_e    state_q, state_d;
  logic          out_req_q, out_req_d;
  logic [DW-1:0] out_data_q, out_data_d;

  la_dsync #(
    .STAGES (STAGES),
    .PROP   (PROP)
  ) u_ack_sync (
    .clk    (clk),
    .nreset (nreset),
    .d_i    (in_ack),
    .q_o    (ack_s)
  );

  // Ready only in IDLE and only once the remote side has returned to idle
  always_comb begin
`ifdef LA_CDC_TX_TWOPHASE_EN
    in_ready = (state_q == StIdle) && (ack_s == out_req_q);
`else
    in_ready = (state_q == StIdle) && !ack_s;
`endif
    accept = in_valid && in_ready;
  end

  // Handshake next-state; out_data only ever loads on the accepting edge
  always_comb begin
    state_d    = state_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          out_data_d = in_data;
`ifdef LA_CDC_TX_TWOPHASE_EN
          out_req_d  = ~out_req_q;
`else
          out_req_d  = 1'b1;
`endif
          state_d    = StReq;
        end
      end
      StReq: begin
`ifdef LA_CDC_TX_TWOPHASE_EN
        if (ack_s == out_req_q) state_d = StIdle;
`else
        if (ack_s) begin
          out_req_d = 1'b0;
          state_d   = StRelease;
        end
`endif
      end
      StRelease: begin
`ifdef LA_CDC_TX_TWOPHASE_EN
        state_d = StIdle;
`else
        if (!ack_s) state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_req  = out_req_q;
  assign out_data = out_data_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_la_cdc_tx.sv
// Bench for la_cdc_tx: directed stimulus, expected words pushed into a
// scoreboard queue and popped by a monitor whenever out_req announces a word.
module tb_la_cdc_tx;

  logic        clk = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        in_ack;
  logic        out_req;
  logic [31:0] out_data;
  logic        busy;

  logic ack_drv;
  logic echo_en;
  logic echo_q = 1'b0;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Remote receiver model: either driven directly or echoing req one cycle late
  always @(posedge clk) echo_q <= out_req;
  assign in_ack = echo_en ? echo_q : ack_drv;

  la_cdc_tx #(
    .DW     (32),
    .STAGES (2),
    .PROP   ("DEFAULT")
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(input logic v, input string nm);
    int n = 0;
    while (out_req !== v && n < 64) begin
      step();
      n++;
    end
    check(nm, {31'd0, out_req}, {31'd0, v});
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    check(nm, {31'd0, busy}, 32'd0);
  endtask

  // Four-phase completion driven by the bench as the remote side
  task automatic handshake(input string nm);
    ack_drv = 1'b1;
    wait_req(1'b0, nm);
    ack_drv = 1'b0;
    wait_idle(nm);
    check({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Monitor: a new word is announced by a req edge; data may only move with req
  initial begin
    logic        prev_req;
    logic [31:0] prev_data;
    logic        announce;
    prev_req  = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        prev_req  = 1'b0;
        prev_data = '0;
      end else begin
`ifdef LA_CDC_TX_TWOPHASE_EN
        announce = (out_req != prev_req);
`else
        announce = out_req && !prev_req;
`endif
        if (announce) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_unexpected: got word %h expected none", out_data);
          end else begin
            pops++;
            check("mon_data", out_data, exp_q.pop_front());
          end
        end
        if (out_req == prev_req) check("mon_stable", out_data, prev_data);
        prev_req  = out_req;
        prev_data = out_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ack_drv  = 1'b0;
    echo_en  = 1'b0;
    repeat (3) step();
    check("rst_req", {31'd0, out_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #2 nreset = 1'b1;
    step();
    check("rst_out_req", {31'd0, out_req}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy_rel", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

`ifndef LA_CDC_TX_TWOPHASE_EN
    // Single transfer with hand-counted ack timing
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0001;
    exp_q.push_back(32'hA5A5_0001);
    step();
    check("single_req", {31'd0, out_req}, 32'd1);
    check("single_data", out_data, 32'hA5A5_0001);
    check("single_busy", {31'd0, busy}, 32'd1);
    check("single_notready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    repeat (5) step();
    check("single_data_held", out_data, 32'hA5A5_0001);
    ack_drv = 1'b1;
    step();
    step();
    check("ack_edge2_req", {31'd0, out_req}, 32'd1);
    step();
    check("ack_edge3_req", {31'd0, out_req}, 32'd0);
    check("release_busy", {31'd0, busy}, 32'd1);
    check("release_notready", {31'd0, in_ready}, 32'd0);
    check("release_data_kept", out_data, 32'hA5A5_0001);
    ack_drv = 1'b0;
    step();
    step();
    check("ackl_edge2_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("ackl_edge3_ready", {31'd0, in_ready}, 32'd1);
    check("ackl_edge3_busy", {31'd0, busy}, 32'd0);
`endif

    // Back-to-back words with the remote echoing req
    echo_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      int n = 0;
      in_valid = 1'b1;
      in_data  = i;
      exp_q.push_back(i);
      while (!in_ready && n < 64) begin
        step();
        n++;
      end
      check("b2b_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("b2b_data", out_data, i);
    end
    in_valid = 1'b0;
    wait_idle("b2b_idle");
    repeat (4) step();
    echo_en = 1'b0;

`ifndef LA_CDC_TX_TWOPHASE_EN
    // Remote ack stuck high across a local reset
    ack_drv = 1'b1;
    step();
    #2 nreset = 1'b0;
    repeat (2) step();
    #2 nreset = 1'b1;
    repeat (4) step();
    check("stuck_notready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h0000_DEAD;
    exp_q.push_back(32'h0000_DEAD);
    repeat (5) step();
    check("stuck_no_req", {31'd0, out_req}, 32'd0);
    check("stuck_no_busy", {31'd0, busy}, 32'd0);
    ack_drv = 1'b0;
    wait_req(1'b1, "stuck_req");
    in_valid = 1'b0;
    check("stuck_data", out_data, 32'h0000_DEAD);
    handshake("stuck_hs");

    // Reset while a request is outstanding
    in_valid = 1'b1;
    in_data  = 32'h0000_0077;
    exp_q.push_back(32'h0000_0077);
    wait_req(1'b1, "abort_req");
    in_valid = 1'b0;
    repeat (2) step();
    check("abort_busy", {31'd0, busy}, 32'd1);
    #2 nreset = 1'b0;
    #1;
    check("abort_req_clr", {31'd0, out_req}, 32'd0);
    check("abort_data_clr", out_data, 32'd0);
    check("abort_busy_clr", {31'd0, busy}, 32'd0);
    repeat (2) step();
    #2 nreset = 1'b1;
    step();
    in_valid = 1'b1;
    in_data  = 32'h0000_0055;
    exp_q.push_back(32'h0000_0055);
    wait_req(1'b1, "post_abort_req");
    in_valid = 1'b0;
    check("post_abort_data", out_data, 32'h0000_0055);
    handshake("post_abort_hs");
    check("sb_pops", pops, 32'd8);
`else
    // Toggle protocol: req goes 0->1->0->1, each word completes on ack_s == req
    step();
    #2 nreset = 1'b0;
    repeat (2) step();
    #2 nreset = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      logic exp_req;
      exp_req  = (k % 2 == 0);
      in_valid = 1'b1;
      in_data  = 32'h100 + k;
      exp_q.push_back(32'h100 + k);
      wait_req(exp_req, "tp_toggle");
      in_valid = 1'b0;
      check("tp_data", out_data, 32'h100 + k);
      check("tp_busy", {31'd0, busy}, 32'd1);
      ack_drv = exp_req;
      step();
      step();
      check("tp_wait", {31'd0, busy}, 32'd1);
      step();
      check("tp_done", {31'd0, busy}, 32'd0);
      check("tp_ready", {31'd0, in_ready}, 32'd1);
    end
    check("sb_pops", pops, 32'd7);
`endif

    step();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
